// File: rtl/fpu_unpack_if.sv
// Operand/bundle handshake bus between the FPU issue logic and the operand unpacker.
interface fpu_unpack_if #(
  parameter int TAG_W = 5
);
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      rs1_i;
  logic [31:0]      rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      rs1_o;
  logic [31:0]      rs2_o;
  logic [9:0]       rs1Exp_o;
  logic [9:0]       rs2Exp_o;
  logic [23:0]      rs1Sig_o;
  logic [23:0]      rs2Sig_o;
  logic [5:0]       rs1Class_o;
  logic [5:0]       rs2Class_o;
  logic [TAG_W-1:0] tag_o;

  // Issue side drives operands and consumes the unpacked bundle.
  modport master (
    output flush_i, in_valid_i, rs1_i, rs2_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, rs1_o, rs2_o, rs1Exp_o, rs2Exp_o,
           rs1Sig_o, rs2Sig_o, rs1Class_o, rs2Class_o, tag_o
  );

  modport slave (
    input  flush_i, in_valid_i, rs1_i, rs2_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, rs1_o, rs2_o, rs1Exp_o, rs2Exp_o,
           rs1Sig_o, rs2Sig_o, rs1Class_o, rs2Class_o, tag_o
  );
endinterface

// File: rtl/fpu_operand_unpack.sv
// Two-stage unpacker: stage 1 classifies and finds the subnormal shift,
// stage 2 shifts the significand and forms the unbiased exponent.
module fpu_operand_unpack #(
  parameter int NORMALIZE_SUBNORM = 1,
  parameter int TAG_W             = 5
) (
  input logic         clk_i,
  input logic         rst_i,
  fpu_unpack_if.slave io
);
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_SNAN = 4;
  localparam int CLS_QNAN = 5;

  logic s1_valid_reg, s2_valid_reg;
  logic s2_adv, s1_adv, accept;
  logic [TAG_W-1:0] s1_tag_reg, s2_tag_reg;

  assign s2_adv        = !s2_valid_reg || io.out_ready_i;
  assign s1_adv        = s1_valid_reg && s2_adv;
  assign io.in_ready_o = !s1_valid_reg || s2_adv;
  assign accept        = io.in_valid_i && io.in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (io.flush_i) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_adv)        s2_valid_reg <= s1_valid_reg;
      if (io.in_ready_o) s1_valid_reg <= io.in_valid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_tag_reg <= '0;
      s2_tag_reg <= '0;
    end else begin
      if (accept) s1_tag_reg <= io.tag_i;
      if (s1_adv) s2_tag_reg <= s1_tag_reg;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_op
    logic [31:0] op_in;
    logic [7:0]  e_in;
    logic [22:0] f_in;
    logic [4:0]  msb_idx;
    logic [5:0]  cls_next;
    logic [4:0]  shamt_next;
    logic [31:0] s1_raw_reg;
    logic [5:0]  s1_cls_reg;
    logic [4:0]  s1_shamt_reg;
    logic [9:0]  exp_next;
    logic [23:0] sig_next;
    logic [31:0] s2_raw_reg;
    logic [9:0]  s2_exp_reg;
    logic [23:0] s2_sig_reg;
    logic [5:0]  s2_cls_reg;

    assign op_in = (gi == 0) ? io.rs1_i : io.rs2_i;
    assign e_in  = op_in[30:23];
    assign f_in  = op_in[22:0];

    always_comb begin
      msb_idx    = '0;
      cls_next   = '0;
      shamt_next = '0;
      for (int i = 0; i < 23; i++) begin
        if (f_in[i]) msb_idx = 5'(i);
      end
      if (e_in == 8'h00) begin
        if (f_in == '0) begin
          cls_next[CLS_ZERO] = 1'b1;
        end else begin
          cls_next[CLS_SUB] = 1'b1;
          // Shift that brings the leading one of F up to the hidden-bit position.
          if (NORMALIZE_SUBNORM != 0) shamt_next = 5'd23 - msb_idx;
        end
      end else if (e_in == 8'hFF) begin
        if (f_in == '0)     cls_next[CLS_INF]  = 1'b1;
        else if (f_in[22])  cls_next[CLS_QNAN] = 1'b1;
        else                cls_next[CLS_SNAN] = 1'b1;
      end else begin
        cls_next[CLS_NORM] = 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_raw_reg   <= '0;
        s1_cls_reg   <= '0;
        s1_shamt_reg <= '0;
      end else if (accept) begin
        s1_raw_reg   <= op_in;
        s1_cls_reg   <= cls_next;
        s1_shamt_reg <= shamt_next;
      end
    end

    always_comb begin
      exp_next = '0;
      sig_next = '0;
      if (s1_cls_reg[CLS_SUB]) begin
        // Every subnormal starts at exponent -126; each shift step lowers it by one.
        sig_next = {1'b0, s1_raw_reg[22:0]} << s1_shamt_reg;
        exp_next = 10'h382 - {5'd0, s1_shamt_reg};
      end else if (s1_cls_reg[CLS_NORM]) begin
        sig_next = {1'b1, s1_raw_reg[22:0]};
        exp_next = {2'b00, s1_raw_reg[30:23]} - 10'd127;
      end else if (s1_cls_reg[CLS_INF]) begin
        sig_next = 24'h800000;
        exp_next = 10'd128;
      end else if (s1_cls_reg[CLS_SNAN] || s1_cls_reg[CLS_QNAN]) begin
        sig_next = {1'b1, s1_raw_reg[22:0]};
        exp_next = 10'd128;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_raw_reg <= '0;
        s2_exp_reg <= '0;
        s2_sig_reg <= '0;
        s2_cls_reg <= '0;
      end else if (s1_adv) begin
        s2_raw_reg <= s1_raw_reg;
        s2_exp_reg <= exp_next;
        s2_sig_reg <= sig_next;
        s2_cls_reg <= s1_cls_reg;
      end
    end
  end

  assign io.out_valid_o = s2_valid_reg;
  assign io.tag_o       = s2_tag_reg;
  assign io.rs1_o       = g_op[0].s2_raw_reg;
  assign io.rs2_o       = g_op[1].s2_raw_reg;
  assign io.rs1Exp_o    = g_op[0].s2_exp_reg;
  assign io.rs2Exp_o    = g_op[1].s2_exp_reg;
  assign io.rs1Sig_o    = g_op[0].s2_sig_reg;
  assign io.rs2Sig_o    = g_op[1].s2_sig_reg;
  assign io.rs1Class_o  = g_op[0].s2_cls_reg;
  assign io.rs2Class_o  = g_op[1].s2_cls_reg;
endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Bench for fpu_operand_unpack: directed and random operand streams checked
// against an arithmetic IEEE-754 decode model and an in-order scoreboard.
module tb_fpu_operand_unpack;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_unpack_if #(.TAG_W(TAG_W)) bus ();

  fpu_operand_unpack #(.NORMALIZE_SUBNORM(1), .TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  typedef struct packed {
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef struct packed {
    logic [9:0]  e;
    logic [23:0] s;
    logic [5:0]  c;
  } unp_t;

  entry_t q[$];
  int total = 0;
  int bad = 0;
  int popped = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode by value: a subnormal is doubled until it reaches [2^23, 2^24).
  function automatic unp_t model(input logic [31:0] x);
    int e, f, s, ex;
    unp_t r;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    r.c = 6'd0;
    if (e == 0 && f == 0) begin
      ex = 0; s = 0; r.c = 6'b000001;
    end else if (e == 0) begin
      s = f; ex = -126; r.c = 6'b000010;
      while (s < 32'h800000) begin
        s = s * 2;
        ex = ex - 1;
      end
    end else if (e == 255 && f == 0) begin
      ex = 128; s = 32'h800000; r.c = 6'b001000;
    end else if (e == 255) begin
      ex = 128; s = f + 32'h800000;
      r.c = x[22] ? 6'b100000 : 6'b010000;
    end else begin
      ex = e - 127; s = f + 32'h800000; r.c = 6'b000100;
    end
    r.e = 10'(ex);
    r.s = 24'(s);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    int bits;
    logic [22:0] f;
    s = 1'($urandom);
    case ($urandom_range(0, 5))
      0: return {s, 31'd0};
      1: begin
        bits = int'($urandom_range(1, 23));
        f = (23'($urandom) & 23'((1 << bits) - 1)) | 23'(1 << (bits - 1));
        return {s, 8'd0, f};
      end
      2: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      3: return {s, 8'hFF, 23'd0};
      4: begin
        f = 23'($urandom) & 23'h3FFFFF;
        if (f == '0) f = 23'd1;
        return {s, 8'hFF, f};
      end
      default: return {s, 8'hFF, 1'b1, 22'($urandom)};
    endcase
  endfunction

  task automatic check_bundle(input entry_t en);
    unp_t a, b;
    a = model(en.rs1);
    b = model(en.rs2);
    check("rs1_o", bus.rs1_o, en.rs1);
    check("rs2_o", bus.rs2_o, en.rs2);
    check("tag_o", 32'(bus.tag_o), 32'(en.tag));
    check("rs1Exp", 32'(bus.rs1Exp_o), 32'(a.e));
    check("rs1Sig", 32'(bus.rs1Sig_o), 32'(a.s));
    check("rs1Class", 32'(bus.rs1Class_o), 32'(a.c));
    check("rs2Exp", 32'(bus.rs2Exp_o), 32'(b.e));
    check("rs2Sig", 32'(bus.rs2Sig_o), 32'(b.s));
    check("rs2Class", 32'(bus.rs2Class_o), 32'(b.c));
  endtask

  // One clock cycle: drive, sample mid-cycle, update the scoreboard, then clock.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input logic ordy, input logic fl);
    logic exp_ready;
    bus.in_valid_i  = v;
    bus.rs1_i       = a;
    bus.rs2_i       = b;
    bus.tag_i       = t;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    #1;
    exp_ready = !(q.size() == 2 && !ordy);
    check("in_ready", 32'(bus.in_ready_o), 32'(exp_ready));
    if (q.size() == 0) check("out_valid_idle", 32'(bus.out_valid_o), 32'd0);
    else if (bus.out_valid_o) check_bundle(q[0]);
    if (fl) begin
      q.delete();
    end else begin
      if (bus.out_valid_o && ordy && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (v && exp_ready) q.push_back('{rs1: a, rs2: b, tag: t});
    end
    $display("cycle t=%0t in_v=%0b rdy=%0b out_v=%0b ordy=%0b flush=%0b pending=%0d",
             $time, v, bus.in_ready_o, bus.out_valid_o, ordy, fl, q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 32'd0, '0, ordy, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] ops1[8], ops2[8];
  int idx, start_pop, cyc;
  logic v, ordy, acc;

  initial begin
    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.rs1_i = '0; bus.rs2_i = '0; bus.tag_i = '0;
    bus.out_ready_i = 1'b0; bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_rs1Class", 32'(bus.rs1Class_o), 32'd0);
    check("rst_rs2Class", 32'(bus.rs2Class_o), 32'd0);
    check("rst_rs1Exp", 32'(bus.rs1Exp_o), 32'd0);
    check("rst_rs1Sig", 32'(bus.rs1Sig_o), 32'd0);
    check("rst_tag", 32'(bus.tag_o), 32'd0);
    rst = 1'b0;

    // Directed 1: normals, 2-cycle latency
    step(1'b1, 32'h3F800000, 32'hC0000000, 5'd3, 1'b1, 1'b0);
    check("t1_lat1", 32'(bus.out_valid_o), 32'd0);
    idle(1'b1);
    check("t1_lat2", 32'(bus.out_valid_o), 32'd1);
    check("t1_rs1Exp", 32'(bus.rs1Exp_o), 32'd0);
    check("t1_rs2Exp", 32'(bus.rs2Exp_o), 32'd1);
    check("t1_rs1Class", 32'(bus.rs1Class_o), 32'h04);
    drain();

    // Directed 2: subnormal extremes
    step(1'b1, 32'h00000001, 32'h00400000, 5'd7, 1'b1, 1'b0);
    idle(1'b1);
    check("t2_rs1Exp", 32'(bus.rs1Exp_o), 32'h36B);
    check("t2_rs2Exp", 32'(bus.rs2Exp_o), 32'(10'h381));
    check("t2_rs1Sig", 32'(bus.rs1Sig_o), 32'h800000);
    check("t2_rs2Class", 32'(bus.rs2Class_o), 32'h02);
    drain();

    // Directed 3: NaNs, infinity, negative zero
    step(1'b1, 32'h7FC00000, 32'h7F800001, 5'd9, 1'b1, 1'b0);
    step(1'b1, 32'h80000000, 32'hFF800000, 5'd10, 1'b1, 1'b0);
    check("t3_rs1Class", 32'(bus.rs1Class_o), 32'h20);
    check("t3_rs2Sig", 32'(bus.rs2Sig_o), 32'h800001);
    check("t3_rs1Sig", 32'(bus.rs1Sig_o), 32'hC00000);
    drain();

    // Directed 4: 8-entry stream with out_ready toggling
    for (int i = 0; i < 8; i++) begin
      ops1[i] = rand_op();
      ops2[i] = rand_op();
    end
    idx = 0;
    cyc = 0;
    start_pop = popped;
    while ((idx < 8 || q.size() > 0) && cyc < 60) begin
      ordy = cyc[0];
      v = (idx < 8);
      acc = v && !(q.size() == 2 && !ordy);
      if (v) step(1'b1, ops1[idx], ops2[idx], 5'(idx), ordy, 1'b0);
      else   idle(ordy);
      if (acc) idx++;
      cyc++;
    end
    check("t4_sent", 32'(idx), 32'd8);
    check("t4_emitted", 32'(popped - start_pop), 32'd8);
    check("t4_pending", 32'(q.size()), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), rand_op(), rand_op(), 5'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    // Directed 5: flush with two in flight plus a concurrent input
    step(1'b1, 32'h40400000, 32'h00000010, 5'd21, 1'b0, 1'b0);
    step(1'b1, 32'h7F800000, 32'h00000000, 5'd22, 1'b0, 1'b0);
    check("t5_full", 32'(q.size()), 32'd2);
    step(1'b1, 32'h41000000, 32'h41000000, 5'd23, 1'b0, 1'b1);
    check("t5_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("t5_in_ready", 32'(bus.in_ready_o), 32'd1);
    repeat (3) idle(1'b1);

    // Directed 6: asynchronous reset mid-stream
    step(1'b1, rand_op(), rand_op(), 5'd1, 1'b1, 1'b0);
    step(1'b1, rand_op(), rand_op(), 5'd2, 1'b1, 1'b0);
    step(1'b1, 32'h3F800000, 32'h3F800000, 5'd3, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("t6_rs1Class", 32'(bus.rs1Class_o), 32'd0);
    check("t6_rs2Class", 32'(bus.rs2Class_o), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 32'hBF000000, 32'h00000003, 5'd30, 1'b1, 1'b0);
    check("t6_lat1", 32'(bus.out_valid_o), 32'd0);
    idle(1'b1);
    check("t6_lat2", 32'(bus.out_valid_o), 32'd1);
    check("t6_tag", 32'(bus.tag_o), 32'd30);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
